// File: rtl/vga_pkg.sv
// vga_pkg: shared display constants and object-table types for the VGA object renderer.
package vga_pkg;
    localparam int H_DISP = 640;
    localparam int V_DISP = 480;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        color_t     color;
    } obj_t;
endpackage

// File: rtl/vga_obj_renderer_if.sv
// vga_obj_renderer_if: object-table write bus between game logic (master) and renderer (slave).
//   obj_we/obj_idx/obj_en/obj_x/obj_y/obj_color : one shadow-slot write per strobe
//   obj_commit                                  : request shadow -> active copy at next frame boundary
//   commit_pending                              : copy requested but not yet performed
interface vga_obj_renderer_if
    import vga_pkg::*;
#(
    parameter int N_OBJ = 8
) ();
    localparam int IW = $clog2(N_OBJ);
    logic          obj_we;
    logic [IW-1:0] obj_idx;
    logic          obj_en;
    logic [9:0]    obj_x;
    logic [9:0]    obj_y;
    color_t        obj_color;
    logic          obj_commit;
    logic          commit_pending;

    modport master (
        output obj_we, obj_idx, obj_en, obj_x, obj_y, obj_color, obj_commit,
        input  commit_pending
    );
    modport slave (
        input  obj_we, obj_idx, obj_en, obj_x, obj_y, obj_color, obj_commit,
        output commit_pending
    );
endinterface

// File: rtl/vga_obj_hit.sv
// vga_obj_hit: combinational test of whether target pixel (tc,tr) lies inside one object rectangle.
//   obj : object descriptor   tc/tr : target column/row   hit : pixel covered by the object
module vga_obj_hit
    import vga_pkg::*;
#(
    parameter int OBJ_W = 16,
    parameter int OBJ_H = 16
) (
    input  obj_t       obj,
    input  logic [9:0] tc,
    input  logic [9:0] tr,
    output logic       hit
);
    // 11-bit right/bottom edges: objects near the screen edge clip instead of wrapping
    logic [10:0] x_end, y_end;
    assign x_end = {1'b0, obj.x} + 11'(OBJ_W);
    assign y_end = {1'b0, obj.y} + 11'(OBJ_H);
    assign hit = obj.en && tc >= obj.x && {1'b0, tc} < x_end && tr >= obj.y && {1'b0, tr} < y_end;
endmodule

// File: rtl/vga_obj_renderer.sv
// vga_obj_renderer: pixel source for vgac drawing a background plus N_OBJ double-buffered rectangles.
//   vga_clk/clrn        : pixel clock, synchronous active-low reset
//   row_addr/col_addr   : current vgac scan position; d_out leads it by 2 cycles
//   obj_bus             : shadow-table writes and commit handshake
//   frame_cnt           : frame boundaries seen (wraps)
//   d_out               : {b,g,r} colour to vgac d_in
//   Optional macro VGA_OBJ_GRID_EN draws GRID_COLOR lines every 32 pixels on the background.
module vga_obj_renderer
    import vga_pkg::*;
#(
    parameter int     N_OBJ      = 8,
    parameter int     OBJ_W      = 16,
    parameter int     OBJ_H      = 16,
    parameter color_t BG_COLOR   = 12'h000,
    parameter color_t GRID_COLOR = 12'h444
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic [9:0]        row_addr,
    input  logic [9:0]        col_addr,
    vga_obj_renderer_if.slave obj_bus,
    output logic [7:0]        frame_cnt,
    output color_t            d_out
);
    logic [9:0]       tc, tr;
    logic             boundary;
    obj_t             shadow [N_OBJ];
    obj_t             active [N_OBJ];
    logic [N_OBJ-1:0] hit, hit_q;
    logic             vis_q;
    color_t           bg, pix;

    // vgac latches d_in one cycle after presenting the address, so look two columns ahead
    assign tc       = col_addr + 10'd2;
    assign tr       = row_addr;
    assign boundary = row_addr == 10'(V_DISP) && col_addr == '0;

    for (genvar i = 0; i < N_OBJ; i++) begin : g_hit
        vga_obj_hit #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_hit (
            .obj(active[i]),
            .tc (tc),
            .tr (tr),
            .hit(hit[i])
        );
    end

`ifdef VGA_OBJ_GRID_EN
    logic grid_q;
    always_ff @(posedge vga_clk)
        grid_q <= clrn && (tc[4:0] == '0 || tr[4:0] == '0);
    assign bg = grid_q ? GRID_COLOR : BG_COLOR;
`else
    logic unused_grid;
    assign unused_grid = ^GRID_COLOR;
    assign bg = BG_COLOR;
`endif

    // scan from the highest slot down so the lowest-index hit wins
    always_comb begin
        pix = bg;
        for (int i = N_OBJ - 1; i >= 0; i--)
            if (hit_q[i]) pix = active[i].color;
    end

    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            obj_bus.commit_pending <= 1'b0;
            frame_cnt              <= '0;
            hit_q                  <= '0;
            vis_q                  <= 1'b0;
            d_out                  <= '0;
        end else begin
            if (obj_bus.obj_we)
                shadow[obj_bus.obj_idx] <= '{en: obj_bus.obj_en, x: obj_bus.obj_x,
                                             y: obj_bus.obj_y, color: obj_bus.obj_color};
            // copy reads the pre-write shadow, so a write in the boundary cycle waits for the next commit
            if (boundary) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (obj_bus.commit_pending || obj_bus.obj_commit) active <= shadow;
                obj_bus.commit_pending <= 1'b0;
            end else if (obj_bus.obj_commit)
                obj_bus.commit_pending <= 1'b1;
            hit_q <= hit;
            vis_q <= tc < 10'(H_DISP) && tr < 10'(V_DISP);
            d_out <= vis_q ? pix : '0;
        end
    end
endmodule

// File: tb/tb_vga_obj_renderer.sv
// tb_vga_obj_renderer: randomized + directed scoreboard bench for vga_obj_renderer against a frame-level model.
module tb_vga_obj_renderer;
    localparam int N = 8;

    typedef struct {int due; int v; int row; int col;} pix_e_t;
    typedef struct {int due; int cp; int fc;} st_e_t;

    logic       vga_clk = 1'b0;
    logic       clrn = 1'b0;
    logic [9:0] row_addr = '0;
    logic [9:0] col_addr = '0;
    logic [7:0] frame_cnt;
    logic [11:0] d_out;

    vga_obj_renderer_if #(.N_OBJ(N)) bus ();

    vga_obj_renderer #(.N_OBJ(N)) dut (
        .vga_clk  (vga_clk),
        .clrn     (clrn),
        .row_addr (row_addr),
        .col_addr (col_addr),
        .obj_bus  (bus),
        .frame_cnt(frame_cnt),
        .d_out    (d_out)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    pix_e_t pix_q[$];
    st_e_t  st_q[$];

    // reference model: shadow and displayed object tables, commit flag, frame counter
    int sh_en[N], sh_x[N], sh_y[N], sh_c[N];
    int ac_en[N], ac_x[N], ac_y[N], ac_c[N];
    int m_cp = 0, m_fc = 0;

    function automatic int exp_pix(int row, int col);
        int tc;
        tc = (col + 2) % 1024;
        if (tc >= 640 || row >= 480) return 0;
        for (int i = 0; i < N; i++)
            if (ac_en[i] != 0 && tc >= ac_x[i] && tc < ac_x[i] + 16 && row >= ac_y[i] && row < ac_y[i] + 16)
                return ac_c[i];
`ifdef VGA_OBJ_GRID_EN
        if (tc % 32 == 0 || row % 32 == 0) return 'h444;
`endif
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_c[i] = 0;
            ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_c[i] = 0;
        end
        m_cp = 0;
        m_fc = 0;
    endtask

    task automatic drive(int row, int col, int we, int idx, int en, int x, int y, int c, int commit);
        row_addr      = 10'(row);
        col_addr      = 10'(col);
        bus.obj_we    = 1'(we);
        bus.obj_idx   = 3'(idx);
        bus.obj_en    = 1'(en);
        bus.obj_x     = 10'(x);
        bus.obj_y     = 10'(y);
        bus.obj_color = 12'(c);
        bus.obj_commit = 1'(commit);
    endtask

    task automatic step(int row, int col, int we, int idx, int en, int x, int y, int c, int commit);
        drive(row, col, we, idx, en, x, y, c, commit);
        pix_q.push_back('{cyc + 2, exp_pix(row, col), row, col});
        if (row == 480 && col == 0) begin
            m_fc = (m_fc + 1) % 256;
            if (m_cp != 0 || commit != 0)
                for (int i = 0; i < N; i++) begin
                    ac_en[i] = sh_en[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_c[i] = sh_c[i];
                end
            m_cp = 0;
        end else if (commit != 0)
            m_cp = 1;
        if (we != 0) begin
            sh_en[idx] = en; sh_x[idx] = x; sh_y[idx] = y; sh_c[idx] = c;
        end
        st_q.push_back('{cyc + 1, m_cp, m_fc});
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset(int n);
        pix_q.delete();
        st_q.delete();
        model_clear();
        clrn = 1'b0;
        repeat (n) begin
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1, $urandom_range(0, 7), 1, 5, 5, 'hFFF, 1);
            pix_q.push_back('{cyc + 1, 0, -1, -1});
            pix_q.push_back('{cyc + 2, 0, -1, -1});
            st_q.push_back('{cyc + 1, 0, 0});
            @(posedge vga_clk);
            #1;
        end
        clrn = 1'b1;
    endtask

    task automatic idle(int row, int col);
        step(row, col, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(int idx, int en, int x, int y, int c);
        step(500, 700, 1, idx, en, x, y, c, 0);
    endtask
    task automatic commit();
        step(500, 700, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic bnd();
        step(480, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge vga_clk) begin
        while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            pix_e_t e;
            e = pix_q.pop_front();
            checks++;
            if (d_out !== 12'(e.v)) begin
                errors++;
                $display("FAIL d_out cyc=%0d row=%0d col=%0d got %h expected %h", cyc, e.row, e.col, d_out, 12'(e.v));
            end
        end
        while (st_q.size() > 0 && st_q[0].due == cyc) begin
            st_e_t s;
            s = st_q.pop_front();
            checks += 2;
            if (bus.commit_pending !== 1'(s.cp)) begin
                errors++;
                $display("FAIL commit_pending cyc=%0d got %b expected %0d", cyc, bus.commit_pending, s.cp);
            end
            if (frame_cnt !== 8'(s.fc)) begin
                errors++;
                $display("FAIL frame_cnt cyc=%0d got %0d expected %0d", cyc, frame_cnt, s.fc);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge vga_clk);
        #1;
        do_reset(3);

        // placement and horizontal edges of a single object
        wr(0, 1, 100, 50, 'h00F);
        commit();
        bnd();
        idle(50, 98); idle(50, 97); idle(50, 113); idle(50, 114); idle(65, 100); idle(66, 100); idle(49, 100);

        // overlap priority, then disable the top object
        wr(0, 1, 200, 200, 'h00F);
        wr(3, 1, 200, 200, 'h0F0);
        commit();
        bnd();
        idle(205, 203);
        wr(0, 0, 200, 200, 'h00F);
        commit();
        commit();
        idle(205, 203);
        bnd();
        idle(205, 203);

        // uncommitted write stays invisible across frames; commit mid-frame waits for the boundary
        wr(1, 1, 300, 300, 'hF00);
        idle(305, 303); bnd(); idle(305, 303); bnd(); idle(305, 303);
        step(300, 10, 0, 0, 0, 0, 0, 0, 1);
        for (int r = 301; r < 480; r += 30) idle(r, 303);
        idle(305, 303);
        bnd();
        idle(305, 303);
        idle(480, 1);

        // commit in the boundary cycle itself, and a write in the boundary cycle
        wr(5, 1, 400, 100, 'h123);
        step(480, 0, 1, 6, 1, 420, 100, 'h456, 1);
        idle(105, 400); idle(105, 420);
        bnd(); idle(105, 420);
        commit(); bnd(); idle(105, 420);

        // clipping at the bottom-right corner
        wr(2, 1, 630, 470, 'hABC);
        commit();
        bnd();
        for (int r = 468; r <= 481; r++)
            for (int t = 627; t <= 641; t++)
                idle(r, t - 2);
        idle(10, 1022); idle(10, 1023);

        // grid positions (plain background without the grid option)
        idle(10, 62); idle(10, 63); idle(32, 10); idle(33, 10);

        // frame counter wrap
        repeat (260) begin
            bnd();
            idle($urandom_range(0, 479), $urandom_range(0, 639));
        end

        // mid-frame reset clears everything
        do_reset(2);
        idle(205, 203); idle(105, 420); idle(474, 632);

        // randomized traffic
        for (int k = 0; k < 20000; k++) begin
            int row, col, we, idx, en, x, y, c, cm, s;
            we = ($urandom_range(0, 99) < 4) ? 1 : 0;
            idx = $urandom_range(0, N - 1);
            en = ($urandom_range(0, 9) < 8) ? 1 : 0;
            if ($urandom_range(0, 1) == 1) begin
                x = $urandom_range(100, 160); y = $urandom_range(100, 160);
            end else begin
                x = $urandom_range(0, 700); y = $urandom_range(0, 500);
            end
            c = $urandom_range(0, 4095);
            cm = ($urandom_range(0, 99) < 2) ? 1 : 0;
            if ($urandom_range(0, 199) == 0) begin
                row = 480; col = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, N - 1);
                row = (ac_y[s] + $urandom_range(0, 19) + 1022) % 1024;
                col = (ac_x[s] + $urandom_range(0, 21) + 1020) % 1024;
            end else begin
                row = $urandom_range(0, 524);
                col = $urandom_range(0, 1023);
            end
            step(row, col, we, idx, en, x, y, c, cm);
            if (k == 10000) do_reset(1);
        end

        repeat (4) idle(500, 700);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
